slink_generic_tx_router: RTL and testbench

SLINK_GENERIC_TX_ROUTER -- requirements
Module: slink_generic_tx_router

---
 rtl/slink_generic_tx_router_if.sv | 36 +++
 rtl/slink_generic_tx_router.sv | 223 ++++++++++++++++++++++
 tb/tb_slink_generic_tx_router.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slink_generic_tx_router_if.sv
// Channel-side and link-side signal bundle for slink_generic_tx_router.
// master = application/link environment, slave = the router.
interface slink_generic_tx_router_if #(
    parameter int NUM_CHANNELS      = 8,
    parameter int TX_APP_DATA_WIDTH = 64
);
    logic [NUM_CHANNELS-1:0]                   tx_sop_ch;
    logic [NUM_CHANNELS-1:0]                   tx_valid_ch;
    logic [NUM_CHANNELS*8-1:0]                 tx_data_id_ch;
    logic [NUM_CHANNELS*16-1:0]                tx_word_count_ch;
    logic [NUM_CHANNELS*TX_APP_DATA_WIDTH-1:0] tx_app_data_ch;
    logic [NUM_CHANNELS-1:0]                   tx_advance_ch;
    logic [7:0]                                swi_sp_max;
    logic                                      tx_sop;
    logic                                      tx_valid;
    logic [7:0]                                tx_data_id;
    logic [15:0]                               tx_word_count;
    logic [TX_APP_DATA_WIDTH-1:0]              tx_app_data;
    logic                                      tx_advance;
    logic [NUM_CHANNELS-1:0]                   tx_active_ch;
    logic                                      tx_timeout;

    modport master (
        output tx_sop_ch, tx_valid_ch, tx_data_id_ch, tx_word_count_ch, tx_app_data_ch,
        output swi_sp_max, tx_advance,
        input  tx_advance_ch, tx_sop, tx_valid, tx_data_id, tx_word_count, tx_app_data,
        input  tx_active_ch, tx_timeout
    );

    modport slave (
        input  tx_sop_ch, tx_valid_ch, tx_data_id_ch, tx_word_count_ch, tx_app_data_ch,
        input  swi_sp_max, tx_advance,
        output tx_advance_ch, tx_sop, tx_valid, tx_data_id, tx_word_count, tx_app_data,
        output tx_active_ch, tx_timeout
    );
endinterface

// File: rtl/slink_generic_tx_router.sv
// Round-robin packet router: arbitrates NUM_CHANNELS application TX channels onto one link.
// Optional stall watchdog enabled by defining SLINK_TX_ROUTER_WATCHDOG_EN.
module slink_generic_tx_router #(
    parameter int NUM_CHANNELS      = 8,
    parameter int TX_APP_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    slink_generic_tx_router_if.slave  link
);
    localparam int BYTES = TX_APP_DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int PTR_W = $clog2(NUM_CHANNELS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]             remaining_q, remaining_d;
    logic                    started_q, started_d;

    logic [NUM_CHANNELS-1:0]      req_s;
    logic [NUM_CHANNELS-1:0]      pick_s;
    logic [PTR_W-1:0]             gidx_s;
    logic [PTR_W-1:0]             next_ptr_s;
    logic                         ch_sop_s;
    logic                         ch_valid_s;
    logic [7:0]                   ch_id_s;
    logic [15:0]                  ch_wc_s;
    logic [TX_APP_DATA_WIDTH-1:0] ch_data_s;
    logic                         in_send_s;
    logic                         accept_s;
    logic [16:0]                  wc_sum_s;
    logic [16:0]                  beats_s;
    logic [15:0]                  first_rem_s;
    logic [15:0]                  rem_now_s;
    logic                         wd_expire_s;
    logic                         finish_s;

    assign req_s     = link.tx_sop_ch & link.tx_valid_ch;
    assign in_send_s = (state_q == SEND);
    assign accept_s  = in_send_s & ch_valid_s & link.tx_advance;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int  idx;
        logic found;
        pick_s = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CHANNELS;
            if (!found && req_s[idx]) begin
                pick_s[idx] = 1'b1;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Binary index of the one-hot grant and the pointer value that follows it.
    always_comb begin
        gidx_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_q[i]) begin
                gidx_s = PTR_W'(i);
            end else begin
                gidx_s = gidx_s;
            end
        end
        if (gidx_s == PTR_W'(NUM_CHANNELS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_s + PTR_W'(1);
        end
    end

    // AND-OR mux of the granted channel; an empty grant yields all zeros.
    always_comb begin
        ch_sop_s   = 1'b0;
        ch_valid_s = 1'b0;
        ch_id_s    = 8'h00;
        ch_wc_s    = 16'h0000;
        ch_data_s  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_q[i]) begin
                ch_sop_s   = ch_sop_s   | link.tx_sop_ch[i];
                ch_valid_s = ch_valid_s | link.tx_valid_ch[i];
                ch_id_s    = ch_id_s    | link.tx_data_id_ch[i*8 +: 8];
                ch_wc_s    = ch_wc_s    | link.tx_word_count_ch[i*16 +: 16];
                ch_data_s  = ch_data_s  | link.tx_app_data_ch[i*TX_APP_DATA_WIDTH +: TX_APP_DATA_WIDTH];
            end else begin
                ch_sop_s = ch_sop_s;
            end
        end
    end

    // Packet length in beats, evaluated on the first beat; 17 bits so 0xFFFF rounds up cleanly.
    always_comb begin
        wc_sum_s = {1'b0, ch_wc_s} + 17'(BYTES - 1);
        beats_s  = wc_sum_s >> BSH;
        if (ch_id_s <= link.swi_sp_max) begin
            beats_s = 17'd1;
        end else if (beats_s == 17'd0) begin
            beats_s = 17'd1;
        end else begin
            beats_s = beats_s;
        end
        first_rem_s = 16'(beats_s - 17'd1);
        if (started_q) begin
            rem_now_s = remaining_q - 16'd1;
        end else begin
            rem_now_s = first_rem_s;
        end
        finish_s = (accept_s && (rem_now_s == 16'd0)) || wd_expire_s;
    end

`ifdef SLINK_TX_ROUTER_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       timeout_q;

    // Watchdog: consecutive stalled SEND cycles after the first beat; the 255th aborts.
    always_comb begin
        wd_expire_s = in_send_s && started_q && !ch_valid_s && (wd_q == 8'd254);
        if (in_send_s && started_q && !ch_valid_s && !wd_expire_s) begin
            wd_d = wd_q + 8'd1;
        end else begin
            wd_d = 8'd0;
        end
    end

    // Watchdog counter and timeout pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= wd_expire_s;
        end
    end

    assign link.tx_timeout = timeout_q;
`else
    assign wd_expire_s     = 1'b0;
    assign link.tx_timeout = 1'b0;
`endif

    // Next-state logic for arbitration and packet tracking.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        started_d   = started_q;
        case (state_q)
            IDLE: begin
                started_d   = 1'b0;
                remaining_d = 16'd0;
                if (|req_s) begin
                    state_d = SEND;
                    grant_d = pick_s;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            SEND: begin
                if (finish_s) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr_s;
                    started_d   = 1'b0;
                    remaining_d = 16'd0;
                end else if (accept_s) begin
                    remaining_d = rem_now_s;
                    started_d   = 1'b1;
                end else begin
                    remaining_d = remaining_q;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                rr_ptr_d    = '0;
                remaining_d = 16'd0;
                started_d   = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= 16'd0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            started_q   <= started_d;
        end
    end

    // Link side follows the granted channel only while in SEND; sop is suppressed after beat one.
    assign link.tx_valid      = in_send_s & ch_valid_s;
    assign link.tx_sop        = in_send_s & ch_valid_s & ch_sop_s & ~started_q;
    assign link.tx_data_id    = in_send_s ? ch_id_s   : 8'h00;
    assign link.tx_word_count = in_send_s ? ch_wc_s   : 16'h0000;
    assign link.tx_app_data   = in_send_s ? ch_data_s : '0;
    assign link.tx_advance_ch = grant_q & {NUM_CHANNELS{accept_s}};
    assign link.tx_active_ch  = grant_q;

endmodule

// File: tb/tb_slink_generic_tx_router.sv
// Directed self-checking bench for slink_generic_tx_router (8 channels, 64-bit link).
module tb_slink_generic_tx_router;
    localparam int NCH = 8;
    localparam int DW  = 64;

    logic clk;
    logic reset_n;

    slink_generic_tx_router_if #(.NUM_CHANNELS(NCH), .TX_APP_DATA_WIDTH(DW)) bus_if ();

    slink_generic_tx_router #(.NUM_CHANNELS(NCH), .TX_APP_DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural channel sources.
    int          pend_r [NCH];
    int          bidx_r [NCH];
    bit          first_r [NCH];
    bit          hold_sop_r [NCH];
    bit          drop_r [NCH];
    logic [7:0]  id_r [NCH];
    logic [15:0] wc_r [NCH];
    logic        adv_en_r;
    logic [7:0]  sp_max_r;

    int n_cmp;
    int n_err;
    int cyc_r;
    int adv_cnt_r [NCH];
    int to_cnt_r;
    int to_cyc_r;
    int acc_ch_q [$];
    int acc_sop_q [$];
    int acc_cyc_q [$];

    always_comb begin
        bus_if.tx_sop_ch        = '0;
        bus_if.tx_valid_ch      = '0;
        bus_if.tx_data_id_ch    = '0;
        bus_if.tx_word_count_ch = '0;
        bus_if.tx_app_data_ch   = '0;
        for (int i = 0; i < NCH; i++) begin
            bus_if.tx_valid_ch[i]             = (pend_r[i] > 0) && !drop_r[i];
            bus_if.tx_sop_ch[i]               = (first_r[i] || hold_sop_r[i]) && (pend_r[i] > 0) && !drop_r[i];
            bus_if.tx_data_id_ch[i*8 +: 8]    = id_r[i];
            bus_if.tx_word_count_ch[i*16 +: 16] = wc_r[i];
            bus_if.tx_app_data_ch[i*DW +: DW] = {24'hC0DE00, 8'(i), 32'(bidx_r[i])};
        end
        bus_if.tx_advance = adv_en_r;
        bus_if.swi_sp_max = sp_max_r;
    end

    // Sources consume a beat shortly after each edge where the router advanced them.
    always @(posedge clk) begin
        logic [NCH-1:0] adv_s;
        adv_s = bus_if.tx_advance_ch;
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (adv_s[i] && pend_r[i] > 0) begin
                pend_r[i]  = pend_r[i] - 1;
                first_r[i] = 1'b0;
                bidx_r[i]  = bidx_r[i] + 1;
            end
        end
    end

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NCH; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Edge monitor: logs accepted link beats and timeout pulses.
    always @(posedge clk) begin
        cyc_r = cyc_r + 1;
        if (reset_n) begin
            for (int i = 0; i < NCH; i++) if (bus_if.tx_advance_ch[i]) adv_cnt_r[i] = adv_cnt_r[i] + 1;
            if (bus_if.tx_valid && bus_if.tx_advance) begin
                acc_ch_q.push_back(onehot_idx(bus_if.tx_active_ch));
                acc_sop_q.push_back(int'(bus_if.tx_sop));
                acc_cyc_q.push_back(cyc_r);
            end
            if (bus_if.tx_timeout) begin
                to_cnt_r = to_cnt_r + 1;
                to_cyc_r = cyc_r;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int ch, input logic [7:0] id, input logic [15:0] wc, input int beats, input bit hs);
        pend_r[ch]     = beats;
        bidx_r[ch]     = 0;
        first_r[ch]    = 1'b1;
        hold_sop_r[ch] = hs;
        drop_r[ch]     = 1'b0;
        id_r[ch]       = id;
        wc_r[ch]       = wc;
    endtask

    task automatic clr();
        for (int i = 0; i < NCH; i++) adv_cnt_r[i] = 0;
        to_cnt_r = 0;
        to_cyc_r = 0;
        acc_ch_q.delete();
        acc_sop_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        bit quiet;
        n     = 0;
        quiet = 1'b0;
        while (!quiet && n < budget) begin
            @(negedge clk);
            n     = n + 1;
            quiet = (bus_if.tx_active_ch == '0) && (bus_if.tx_valid_ch == '0);
        end
        check_eq(tag, 64'(quiet), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int sops;
        n_cmp    = 0;
        n_err    = 0;
        cyc_r    = 0;
        adv_en_r = 1'b1;
        sp_max_r = 8'h2F;
        for (int i = 0; i < NCH; i++) begin
            pend_r[i] = 0; bidx_r[i] = 0; first_r[i] = 1'b0; hold_sop_r[i] = 1'b0;
            drop_r[i] = 1'b0; id_r[i] = 8'h00; wc_r[i] = 16'h0000;
        end
        clr();
        reset_n = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid",  64'(bus_if.tx_valid), 64'd0);
        check_eq("rst_active", 64'(bus_if.tx_active_ch), 64'd0);
        check_eq("rst_adv",    64'(bus_if.tx_advance_ch), 64'd0);
        check_eq("rst_to",     64'(bus_if.tx_timeout), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Short packet on ch2
        @(negedge clk);
        clr();
        load(2, 8'h10, 16'd4, 1, 1'b0);
        @(negedge clk);
        check_eq("sp_valid",  64'(bus_if.tx_valid), 64'd1);
        check_eq("sp_sop",    64'(bus_if.tx_sop), 64'd1);
        check_eq("sp_id",     64'(bus_if.tx_data_id), 64'h10);
        check_eq("sp_adv",    64'(bus_if.tx_advance_ch), 64'h04);
        check_eq("sp_active", 64'(bus_if.tx_active_ch), 64'h04);
        check_eq("sp_data",   bus_if.tx_app_data, 64'hC0DE0002_00000000);
        @(negedge clk);
        check_eq("sp_idle_valid",  64'(bus_if.tx_valid), 64'd0);
        check_eq("sp_idle_active", 64'(bus_if.tx_active_ch), 64'd0);
        check_eq("sp_cnt",         64'(adv_cnt_r[2]), 64'd1);

        // Ch0 and ch1 simultaneous 2-beat packets; ch0 keeps sop asserted
        clr();
        load(0, 8'h40, 16'd16, 2, 1'b1);
        load(1, 8'h40, 16'd16, 2, 1'b0);
        wait_quiet("rr_done", 50);
        check_eq("rr_n",    64'(acc_ch_q.size()), 64'd4);
        check_eq("rr_ch0",  64'(acc_ch_q[0]), 64'd0);
        check_eq("rr_ch1",  64'(acc_ch_q[1]), 64'd0);
        check_eq("rr_ch2",  64'(acc_ch_q[2]), 64'd1);
        check_eq("rr_ch3",  64'(acc_ch_q[3]), 64'd1);
        check_eq("rr_sop0", 64'(acc_sop_q[0]), 64'd1);
        check_eq("rr_sop1", 64'(acc_sop_q[1]), 64'd0);
        check_eq("rr_sop2", 64'(acc_sop_q[2]), 64'd1);
        check_eq("rr_sop3", 64'(acc_sop_q[3]), 64'd0);
        check_eq("rr_b2b",  64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd1);
        check_eq("rr_gap",  64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd2);

        // Beat-count boundaries
        clr();
        @(negedge clk);
        load(0, 8'h40, 16'd17, 3, 1'b1);
        wait_quiet("wc17_done", 50);
        check_eq("wc17_cnt", 64'(adv_cnt_r[0]), 64'd3);
        sops = 0;
        foreach (acc_sop_q[i]) sops = sops + acc_sop_q[i];
        check_eq("wc17_sops", 64'(sops), 64'd1);
        clr();
        load(5, 8'h40, 16'd0, 1, 1'b0);
        wait_quiet("wc0_done", 50);
        check_eq("wc0_cnt", 64'(adv_cnt_r[5]), 64'd1);
        clr();
        load(7, 8'h2F, 16'd100, 1, 1'b0);
        wait_quiet("spmax_done", 50);
        check_eq("spmax_cnt", 64'(adv_cnt_r[7]), 64'd1);
        clr();
        load(6, 8'h30, 16'd8, 1, 1'b0);
        wait_quiet("wc8_done", 50);
        check_eq("wc8_cnt", 64'(adv_cnt_r[6]), 64'd1);

        // Link stall mid-packet with ch1 pending; swi_sp_max raised after first beat
        clr();
        @(negedge clk);
        load(4, 8'h30, 16'd24, 3, 1'b0);
        @(negedge clk);
        check_eq("stall_grant", 64'(bus_if.tx_active_ch), 64'h10);
        @(negedge clk);
        adv_en_r = 1'b0;
        sp_max_r = 8'hFF;
        load(1, 8'h05, 16'd2, 1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("stall_active", 64'(bus_if.tx_active_ch), 64'h10);
            check_eq("stall_adv",    64'(bus_if.tx_advance_ch), 64'h00);
            check_eq("stall_valid",  64'(bus_if.tx_valid), 64'd1);
            check_eq("stall_sop",    64'(bus_if.tx_sop), 64'd0);
        end
        adv_en_r = 1'b1;
        wait_quiet("stall_done", 50);
        check_eq("stall_cnt4", 64'(adv_cnt_r[4]), 64'd3);
        check_eq("stall_cnt1", 64'(adv_cnt_r[1]), 64'd1);
        check_eq("stall_last", 64'(acc_ch_q[acc_ch_q.size()-1]), 64'd1);
        sp_max_r = 8'h2F;

        // Move rr_ptr past 3, then reset in the middle of a 4-beat ch0 packet
        clr();
        load(4, 8'h01, 16'd1, 1, 1'b0);
        wait_quiet("pre_rst_done", 50);
        clr();
        load(0, 8'h40, 16'd32, 4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mrst_valid",  64'(bus_if.tx_valid), 64'd0);
        check_eq("mrst_sop",    64'(bus_if.tx_sop), 64'd0);
        check_eq("mrst_active", 64'(bus_if.tx_active_ch), 64'd0);
        check_eq("mrst_adv",    64'(bus_if.tx_advance_ch), 64'd0);
        check_eq("mrst_id",     64'(bus_if.tx_data_id), 64'd0);
        for (int i = 0; i < NCH; i++) pend_r[i] = 0;
        @(negedge clk);
        check_eq("mrst_cnt0", 64'(adv_cnt_r[0]), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);
        clr();
        load(3, 8'h01, 16'd1, 1, 1'b0);
        load(6, 8'h01, 16'd1, 1, 1'b0);
        @(negedge clk);
        check_eq("post_rst_grant", 64'(bus_if.tx_active_ch), 64'h08);
        wait_quiet("post_rst_done", 50);
        check_eq("post_rst_first", 64'(acc_ch_q[0]), 64'd3);

        // Granted ch2 drops valid after its first beat while ch5 waits
        clr();
        load(2, 8'h40, 16'd16, 2, 1'b0);
        @(negedge clk);
        check_eq("wd_grant", 64'(bus_if.tx_active_ch), 64'h04);
        @(negedge clk);
        drop_r[2] = 1'b1;
        load(5, 8'h01, 16'd1, 1, 1'b0);
`ifdef SLINK_TX_ROUTER_WATCHDOG_EN
        for (int k = 0; k < 300 && to_cnt_r == 0; k++) @(negedge clk);
        check_eq("wd_pulses", 64'(to_cnt_r), 64'd1);
        check_eq("wd_delay",  64'(to_cyc_r - acc_cyc_q[0]), 64'd256);
        pend_r[2] = 0;
        drop_r[2] = 1'b0;
        wait_quiet("wd_done", 50);
        check_eq("wd_cnt2", 64'(adv_cnt_r[2]), 64'd1);
        check_eq("wd_cnt5", 64'(adv_cnt_r[5]), 64'd1);
        check_eq("wd_single", 64'(to_cnt_r), 64'd1);
`else
        repeat (300) @(negedge clk);
        check_eq("hold_active", 64'(bus_if.tx_active_ch), 64'h04);
        check_eq("hold_valid",  64'(bus_if.tx_valid), 64'd0);
        check_eq("hold_adv",    64'(bus_if.tx_advance_ch), 64'd0);
        check_eq("hold_to",     64'(to_cnt_r), 64'd0);
        drop_r[2] = 1'b0;
        wait_quiet("hold_done", 50);
        check_eq("hold_cnt2", 64'(adv_cnt_r[2]), 64'd2);
        check_eq("hold_cnt5", 64'(adv_cnt_r[5]), 64'd1);
        check_eq("hold_last", 64'(acc_ch_q[acc_ch_q.size()-1]), 64'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
